// File: rtl/vcb_seq_ctrl.sv
// Sequencer for an external loadable up/down counter: clear, load, prescaled
// counting and terminal-count tracking until the requested number of wraps is seen.
module vcb_seq_ctrl #(
   parameter int WIDTH    = 4,
   parameter int WRAP_W   = 4,
   parameter int PRESCALE = 2
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  preset,
   input  logic              dir_up,
   input  logic [WRAP_W-1:0] wraps,
   input  logic [WIDTH-1:0]  cnt_q,
   input  logic              cnt_ceo,
   output logic              cnt_ce,
   output logic              cnt_l,
   output logic              cnt_up,
   output logic [WIDTH-1:0]  cnt_di,
   output logic              cnt_clr,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_cnt
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PS_W-1:0]     presc;
   logic [WIDTH-1:0]    preset_r;
   logic                dir_r;
   logic [WRAP_W-1:0]   wraps_r;
   logic                accept;
   logic                tick;
   logic                term_hit;
   logic                last_wrap;
   logic                unused_cnt_q;

   // Counter Q is status only; it never steers the sequence.
   assign unused_cnt_q = ^cnt_q;

   assign accept    = (state == S_IDLE) && start && !abort;
   assign tick      = (state == S_RUN) && (presc == PS_LAST);
   assign term_hit  = (state == S_RUN) && cnt_ceo && !abort;
   assign last_wrap = (wrap_cnt == wraps_r);

   assign cnt_up = dir_r;
   assign cnt_di = preset_r;
   assign busy   = (state != S_IDLE);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_ce    = 1'b0;
      cnt_l     = 1'b0;
      cnt_clr   = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_clr   = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            cnt_l     = 1'b1;
            cnt_ce    = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            cnt_ce = tick;
            if (cnt_ceo && last_wrap) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = !abort;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort overrides every other transition, including a start seen in IDLE.
      if (abort) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         preset_r <= '0;
         dir_r    <= 1'b0;
         wraps_r  <= '0;
         wrap_cnt <= '0;
         presc    <= '0;
      end else begin
         if (accept) begin
            preset_r <= preset;
            dir_r    <= dir_up;
            wraps_r  <= wraps;
            wrap_cnt <= '0;
         end
         if (state == S_LOAD) begin
            presc <= '0;
         end else if (state == S_RUN) begin
            presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
         end
         // Exit happens on the terminal count matching wraps_r, so wrap_cnt cannot overflow.
         if (term_hit && !last_wrap) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vcb_seq_ctrl.sv
// Bench for vcb_seq_ctrl: two instances (PRESCALE 2 and 1) each driving a
// behavioural up/down counter; expected tick and done cycles are queued at start.
module tb_vcb_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr_n, start0, start1, abort0, abort1, dir_up;
   logic [3:0] preset, wraps;

   logic       ce0, l0, up0, clr0, busy0, done0, ceo0;
   logic [3:0] di0, wc0;
   logic [3:0] q0 = 4'd0;
   logic       ce1, l1, up1, clr1, busy1, done1, ceo1;
   logic [3:0] di1, wc1;
   logic [3:0] q1 = 4'd0;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int tq0[$];
   int dq0[$];
   int tq1[$];
   int dq1[$];

   vcb_seq_ctrl #(.WIDTH(4), .WRAP_W(4), .PRESCALE(2)) u0 (
      .clk(clk), .clr_n(clr_n), .start(start0), .abort(abort0),
      .preset(preset), .dir_up(dir_up), .wraps(wraps),
      .cnt_q(q0), .cnt_ceo(ceo0),
      .cnt_ce(ce0), .cnt_l(l0), .cnt_up(up0), .cnt_di(di0), .cnt_clr(clr0),
      .busy(busy0), .done(done0), .wrap_cnt(wc0)
   );

   vcb_seq_ctrl #(.WIDTH(4), .WRAP_W(4), .PRESCALE(1)) u1 (
      .clk(clk), .clr_n(clr_n), .start(start1), .abort(abort1),
      .preset(preset), .dir_up(dir_up), .wraps(wraps),
      .cnt_q(q1), .cnt_ceo(ceo1),
      .cnt_ce(ce1), .cnt_l(l1), .cnt_up(up1), .cnt_di(di1), .cnt_clr(clr1),
      .busy(busy1), .done(done1), .wrap_cnt(wc1)
   );

   // External counter stand-ins: sync clear, load with ce, count with ce.
   always @(posedge clk) begin
      if (clr0) q0 <= 4'd0;
      else if (ce0) q0 <= l0 ? di0 : (up0 ? q0 + 4'd1 : q0 - 4'd1);
      if (clr1) q1 <= 4'd0;
      else if (ce1) q1 <= l1 ? di1 : (up1 ? q1 + 4'd1 : q1 - 4'd1);
   end
   assign ceo0 = ce0 & (up0 ? (q0 == 4'hF) : (q0 == 4'h0));
   assign ceo1 = ce1 & (up1 ? (q1 == 4'hF) : (q1 == 4'h0));

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int inst, input int p, input bit up,
                           input int w, input int ps);
      int n;
      n = (up ? 15 - p : p) + 1 + w * 16;
      for (int i = 1; i <= n; i++) begin
         if (inst == 0) tq0.push_back(2 + ps * i);
         else           tq1.push_back(2 + ps * i);
      end
      if (inst == 0) dq0.push_back(2 + ps * n + 1);
      else           dq1.push_back(2 + ps * n + 1);
   endtask

   task automatic go0(input int p, input bit up, input int w);
      preset = 4'(p);
      dir_up = up;
      wraps  = 4'(w);
      start0 = 1'b1;
      cyc    = 0;
      push_exp(0, p, up, w, 2);
   endtask

   task automatic mon();
      int e;
      if (ce0 && !l0) begin
         chk("u0_tick_no_clr", clr0, 0);
         if (tq0.size() == 0) chk("u0_tick_unexpected", cyc, -1);
         else begin e = tq0.pop_front(); chk("u0_tick_cycle", cyc, e); end
      end
      if (done0) begin
         if (dq0.size() == 0) chk("u0_done_unexpected", cyc, -1);
         else begin e = dq0.pop_front(); chk("u0_done_cycle", cyc, e); end
      end
      if (!busy0) chk("u0_idle_quiet", {ce0, l0, clr0, done0}, 0);
      if (ce1 && !l1) begin
         if (tq1.size() == 0) chk("u1_tick_unexpected", cyc, -1);
         else begin e = tq1.pop_front(); chk("u1_tick_cycle", cyc, e); end
      end
      if (done1) begin
         if (dq1.size() == 0) chk("u1_done_unexpected", cyc, -1);
         else begin e = dq1.pop_front(); chk("u1_done_cycle", cyc, e); end
      end
      if (!busy1) chk("u1_idle_quiet", {ce1, l1, clr1, done1}, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      start0 = 1'b0;
      start1 = 1'b0;
      abort0 = 1'b0;
      abort1 = 1'b0;
      mon();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   initial begin
      clr_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      abort0 = 1'b0;
      abort1 = 1'b0;
      dir_up = 1'b0;
      preset = 4'd0;
      wraps  = 4'd0;

      #12;
      chk("rst_u0_ctrl", {ce0, l0, up0, clr0, busy0, done0}, 0);
      chk("rst_u0_di", di0, 0);
      chk("rst_u0_wrap", wc0, 0);
      chk("rst_u1_ctrl", {ce1, l1, up1, clr1, busy1, done1}, 0);
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      step();
      step();

      // Test 1: preset 6, up, no extra wraps
      go0(6, 1'b1, 0);
      step();
      chk("t1_clr", clr0, 1);
      chk("t1_busy", busy0, 1);
      chk("t1_up_in_clear", up0, 1);
      step();
      chk("t1_load", {l0, ce0, clr0}, 3'b110);
      chk("t1_di", di0, 6);
      run_to(24);
      chk("t1_busy_end", busy0, 0);
      chk("t1_sb_empty", tq0.size() + dq0.size(), 0);
      chk("t1_wrap", wc0, 0);
      chk("t1_up_held", up0, 1);

      // Test 2: preset 6, down, one extra wrap -> 23 ticks
      step();
      go0(6, 1'b0, 1);
      step();
      chk("t2_up_in_clear", up0, 0);
      run_to(16);
      chk("t2_wrap_before7", wc0, 0);
      step();
      chk("t2_wrap_after7", wc0, 1);
      run_to(50);
      chk("t2_busy_end", busy0, 0);
      chk("t2_sb_empty", tq0.size() + dq0.size(), 0);
      chk("t2_wrap_final", wc0, 1);

      // Test 3: PRESCALE=1 instance, preset 15 up -> immediate terminal count
      step();
      preset = 4'd15;
      dir_up = 1'b1;
      wraps  = 4'd0;
      start1 = 1'b1;
      cyc    = 0;
      push_exp(1, 15, 1'b1, 0, 1);
      run_to(3);
      chk("t3_ceo", ceo1, 1);
      run_to(5);
      chk("t3_busy_end", busy1, 0);
      chk("t3_sb_empty", tq1.size() + dq1.size(), 0);

      // Test 4: second start while busy is ignored
      step();
      go0(6, 1'b1, 0);
      run_to(10);
      preset = 4'd3;
      dir_up = 1'b0;
      wraps  = 4'd5;
      start0 = 1'b1;
      run_to(24);
      chk("t4_busy_end", busy0, 0);
      chk("t4_sb_empty", tq0.size() + dq0.size(), 0);
      chk("t4_up_kept", up0, 1);
      chk("t4_di_kept", di0, 6);

      // Test 5: abort mid-run, abort beats start, abort beats ceo
      step();
      go0(6, 1'b1, 0);
      run_to(12);
      abort0 = 1'b1;
      tq0.delete();
      dq0.delete();
      step();
      chk("t5_abort_idle", busy0, 0);
      chk("t5_abort_ce", ce0, 0);
      run_to(30);
      preset = 4'd6;
      dir_up = 1'b1;
      wraps  = 4'd0;
      start0 = 1'b1;
      abort0 = 1'b1;
      step();
      chk("t5_abort_beats_start", busy0, 0);
      go0(6, 1'b1, 0);
      run_to(24);
      chk("t5_restart_end", busy0, 0);
      chk("t5_restart_sb", tq0.size() + dq0.size(), 0);
      step();
      go0(15, 1'b1, 0);
      run_to(4);
      chk("t5_ceo_seen", ceo0, 1);
      abort0 = 1'b1;
      dq0.delete();
      step();
      chk("t5_abort_beats_ceo", busy0, 0);
      run_to(10);

      // Test 6: asynchronous reset in the middle of test 2, then rerun
      step();
      go0(6, 1'b0, 1);
      run_to(8);
      chk("t6_busy_pre", busy0, 1);
      #2;
      clr_n = 1'b0;
      #1;
      chk("t6_async_ctrl", {ce0, l0, up0, clr0, busy0, done0}, 0);
      chk("t6_async_di", di0, 0);
      chk("t6_async_wrap", wc0, 0);
      tq0.delete();
      dq0.delete();
      #1;
      clr_n = 1'b1;
      step();
      go0(6, 1'b0, 1);
      run_to(50);
      chk("t6_busy_end", busy0, 0);
      chk("t6_sb_empty", tq0.size() + dq0.size(), 0);
      chk("t6_wrap_final", wc0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
